branch_predictor_320: RTL and testbench
=======================================

BRANCH_PREDICTOR_320 -- requirements
Module: branch_predictor_320

Interface
REQ-001 Parameter IDX_W, default 6, meaning: pattern-table index width, giving 64 entries indexed by pc[IDX_W+1:2].
REQ-002 Parameter QDEPTH, default 4, meaning: in-flight prediction queue depth, a power of two.
REQ-003 clk  in  1  single clock; all state updates occur on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 stall  in  1  fetch/ID frozen (pipeline bubble); suppresses lookup push.
REQ-006 id_branch  in  1  ID stage holds a conditional branch this cycle.
REQ-007 id_pc  in  32  address of the ID-stage instruction.
REQ-008 predict  out  1  taken prediction for id_pc, combinational from table MSB.
REQ-009 mem_branch  in  1  MEM stage resolves a conditional branch this cycle.
REQ-010 mem_pc  in  32  address of the resolving branch.
REQ-011 mem_taken  in  1  actual branch outcome.
REQ-012 mem_target  in  32  computed taken target, mem_pc + (sext(imm16)<<2).
REQ-013 flush  out  1  one-cycle mispredict pulse, which drives the fetch unit's regReset.
REQ-014 redirect_pc  out  32  correct-path address, valid while flush=1.
REQ-015 q_full  out  1  queue full; the pipeline shall stall on a branch in ID.
REQ-016 br_count, miss_count  out  16 each  saturating statistics counters.
REQ-017 q_err  out  1  sticky flag: resolve seen with queue empty.

Function
REQ-018 Table: 2^IDX_W two-bit saturating counters; predict = counter[idx(id_pc)][1].
REQ-019 Push {idx, predict} to the queue when id_branch & !stall & !q_full & !flush.
REQ-020 Pop the queue head when mem_branch=1; the popped predicted bit is compared with mem_taken.
REQ-021 Simultaneous push and pop is legal in any occupancy, including full; occupancy is unchanged.
REQ-022 Counter update on mem_branch: mem_taken increments saturating at 3; otherwise it decrements saturating at 0.
REQ-023 Same-cycle lookup and update of one index: predict uses the pre-update value.
REQ-024 Mismatch registers flush=1 for exactly the next cycle.
REQ-025 redirect_pc = mem_target if mem_taken, else mem_pc+4, and is registered with flush.
REQ-026 FSM states: RUN, FLUSH, DRAIN.
  - RUN to FLUSH on mismatch.
  - FLUSH to DRAIN after 1 cycle.
  - DRAIN to RUN after 2 cycles.
REQ-027 In FLUSH the queue is cleared to empty; pushes are ignored in FLUSH and DRAIN, because those are wrong-path fetches.
REQ-028 In FLUSH and DRAIN, mem_branch still updates the table but never pops or flushes.
REQ-029 Pop with queue empty in RUN: treat predicted=0, set q_err, and apply the table update.
REQ-030 br_count increments per resolved branch; miss_count increments per flush; both hold at 16'hFFFF.
REQ-031 Queue pointers wrap modulo QDEPTH; occupancy counter width is log2(QDEPTH)+1.

Reset
REQ-032 rst_n low asynchronously sets every table counter to 2'b01 (weakly not-taken).
REQ-033 rst_n low asynchronously sets: queue empty, FSM=RUN, flush=0, redirect_pc=0, q_full=0, q_err=0, counters=0.
REQ-034 Reset asserted mid-FLUSH or mid-DRAIN aborts the sequence; the first cycle after release is RUN with no flush.

Structure
REQ-035 The shared package holds the FSM state encoding, counter constants (SNT=0, WNT=1, WT=2, ST=3), and the DRAIN length constant 2.
REQ-036 The in-flight queue is one sub-module, pred_fifo_320, with push/pop/clear/full/empty ports.
REQ-037 Only storage is sequential; redirect arithmetic uses 32-bit unsigned adds with wrap.

Verification
REQ-038 Reset, then id_branch at pc 0x40 -> predict=0; push occurs; q_full=0.
REQ-039 Resolve pc 0x40 taken three times with correct prior predictions forced -> counter[16] reaches 3 and holds at 3 on a fourth taken.
REQ-040 Predict 0 at pc 0x40, resolve taken with target 0x80 -> flush=1 for one cycle, redirect_pc=0x80, queue empty, miss_count=1.
REQ-041 Predict 1, resolve not-taken at pc 0x100 -> redirect_pc=0x104; pushes during the next 3 cycles are ignored.
REQ-042 Four pushes with no pop -> q_full=1; a fifth push with a simultaneous pop -> occupancy stays 4.
REQ-043 Lookup and update of index 5 in the same cycle with the counter at 1 and outcome taken -> predict=0 that cycle and 1 the next.

Source files
------------

// File: rtl/branch_predictor_320_pkg.sv
// Shared definitions for the branch predictor slice.
// Contents:
//   state_e      - recovery FSM encoding (RUN, FLUSH, DRAIN)
//   CNT_*        - two-bit saturating counter values
//   DRAIN_LEN    - number of DRAIN cycles after a flush
//   sat_update   - next value of a two-bit counter given the outcome
//   sat_inc16    - 16-bit increment that holds at all-ones
package branch_predictor_320_pkg;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam logic [1:0] CNT_SNT = 2'd0;
   localparam logic [1:0] CNT_WNT = 2'd1;
   localparam logic [1:0] CNT_WT  = 2'd2;
   localparam logic [1:0] CNT_ST  = 2'd3;

   localparam int unsigned DRAIN_LEN = 32'd2;

   function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] nxt;
      nxt = cnt;
      if (taken) begin
         if (cnt != CNT_ST) nxt = cnt + 2'd1;
         else               nxt = cnt;
      end else begin
         if (cnt != CNT_SNT) nxt = cnt - 2'd1;
         else                nxt = cnt;
      end
      return nxt;
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      logic [15:0] nxt;
      if (v == 16'hFFFF) nxt = v;
      else               nxt = v + 16'd1;
      return nxt;
   endfunction

endpackage

// File: rtl/branch_predictor_320_if.sv
// Pipeline <-> predictor bus.
//   master: pipeline side, drives ID/MEM information and reads prediction,
//           flush/redirect, queue status and statistics.
//   slave : predictor side, the mirror image.
interface branch_predictor_320_if;
   logic        stall;
   logic        id_branch;
   logic [31:0] id_pc;
   logic        predict;
   logic        mem_branch;
   logic [31:0] mem_pc;
   logic        mem_taken;
   logic [31:0] mem_target;
   logic        flush;
   logic [31:0] redirect_pc;
   logic        q_full;
   logic [15:0] br_count;
   logic [15:0] miss_count;
   logic        q_err;

   modport master (
      output stall, id_branch, id_pc, mem_branch, mem_pc, mem_taken, mem_target,
      input  predict, flush, redirect_pc, q_full, br_count, miss_count, q_err
   );

   modport slave (
      input  stall, id_branch, id_pc, mem_branch, mem_pc, mem_taken, mem_target,
      output predict, flush, redirect_pc, q_full, br_count, miss_count, q_err
   );
endinterface

// File: rtl/branch_predictor_320_fifo.sv
// pred_fifo_320: in-flight prediction queue between ID and MEM.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   push, wdata  - enqueue request and data (accepted when not full or popping)
//   pop, rdata   - dequeue request, head entry (rdata valid when !empty)
//   clear        - synchronous empty, dominates push/pop
//   full, empty  - occupancy status
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module pred_fifo_320
   import branch_predictor_320_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             clear,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PW-1:0]    wr_ptr_r;
   logic [PW-1:0]    rd_ptr_r;
   logic [CW-1:0]    count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign full  = (count_r == CW'(DEPTH));
   assign empty = (count_r == {CW{1'b0}});
   assign rdata = mem_r[rd_ptr_r];

   // Qualify requests: a full queue still accepts a push when the head leaves the same cycle.
   always_comb begin
      do_push_s = 1'b0;
      do_pop_s  = 1'b0;
      if (clear) begin
         do_push_s = 1'b0;
         do_pop_s  = 1'b0;
      end else begin
         do_pop_s  = pop & ~empty;
         do_push_s = push & (~full | do_pop_s);
      end
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (clear) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            mem_r[wr_ptr_r] <= wdata;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (do_pop_s) rd_ptr_r <= rd_ptr_r + PW'(1);
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/branch_predictor_320.sv
// branch_predictor_320: bimodal predictor with an in-flight prediction queue
// and mispredict recovery.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of branch_predictor_320_if:
//                ID lookup (id_branch/id_pc/stall -> predict), MEM resolve
//                (mem_branch/mem_pc/mem_taken/mem_target), recovery
//                (flush/redirect_pc), queue status (q_full/q_err) and
//                saturating statistics (br_count/miss_count).
module branch_predictor_320
   import branch_predictor_320_pkg::*;
#(
   parameter int IDX_W  = 6,
   parameter int QDEPTH = 4
) (
   input logic                    clk,
   input logic                    rst_n,
   branch_predictor_320_if.slave  bus
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int QENT_W  = IDX_W + 1;

   logic [1:0]        pht_r [ENTRIES];
   state_e            state_r;
   logic [1:0]        drain_cnt_r;
   logic              flush_r;
   logic [31:0]       redirect_r;
   logic [15:0]       br_cnt_r;
   logic [15:0]       miss_cnt_r;
   logic              q_err_r;

   logic [IDX_W-1:0]  id_idx_s;
   logic [IDX_W-1:0]  mem_idx_s;
   logic              predict_s;
   logic              running_s;
   logic              push_s;
   logic              pop_s;
   logic              head_pred_s;
   logic              mispredict_s;
   logic              empty_pop_s;
   logic [31:0]       redirect_next_s;
   logic              fifo_full_s;
   logic              fifo_empty_s;
   logic              fifo_clear_s;
   logic [QENT_W-1:0] fifo_rdata_s;
   logic              unused_bits_s;

   assign id_idx_s      = bus.id_pc[IDX_W+1:2];
   assign mem_idx_s     = bus.mem_pc[IDX_W+1:2];
   // Lookup reads the array before any same-cycle update lands.
   assign predict_s     = pht_r[id_idx_s][1];
   assign fifo_clear_s  = (state_r == FLUSH);
   assign unused_bits_s = ^{bus.id_pc[31:IDX_W+2], bus.id_pc[1:0], fifo_rdata_s[QENT_W-1:1]};

   // Push/pop qualification, mispredict detection and redirect address.
   always_comb begin
      running_s       = (state_r == RUN);
      pop_s           = 1'b0;
      push_s          = 1'b0;
      head_pred_s     = 1'b0;
      mispredict_s    = 1'b0;
      empty_pop_s     = 1'b0;
      redirect_next_s = 32'd0;
      if (running_s) begin
         pop_s  = bus.mem_branch;
         push_s = bus.id_branch & ~bus.stall & ~flush_r & (~fifo_full_s | pop_s);
      end else begin
         pop_s  = 1'b0;
         push_s = 1'b0;
      end
      // An empty-queue resolve is treated as a not-taken prediction.
      if (fifo_empty_s) head_pred_s = 1'b0;
      else              head_pred_s = fifo_rdata_s[0];
      empty_pop_s  = pop_s & fifo_empty_s;
      mispredict_s = pop_s & (head_pred_s != bus.mem_taken);
      if (bus.mem_taken) redirect_next_s = bus.mem_target;
      else               redirect_next_s = bus.mem_pc + 32'd4;
   end

   pred_fifo_320 #(
      .WIDTH (QENT_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push_s),
      .pop   (pop_s),
      .clear (fifo_clear_s),
      .wdata ({id_idx_s, predict_s}),
      .rdata (fifo_rdata_s),
      .full  (fifo_full_s),
      .empty (fifo_empty_s)
   );

   // Pattern table: every resolved branch trains its counter, whatever the FSM state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) pht_r[i] <= CNT_WNT;
      end else if (bus.mem_branch) begin
         pht_r[mem_idx_s] <= sat_update(pht_r[mem_idx_s], bus.mem_taken);
      end
   end

   // Recovery FSM with its registered flush, redirect and miss statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= RUN;
         drain_cnt_r <= 2'd0;
         flush_r     <= 1'b0;
         redirect_r  <= 32'd0;
         miss_cnt_r  <= 16'd0;
      end else begin
         case (state_r)
            RUN: begin
               if (mispredict_s) begin
                  state_r    <= FLUSH;
                  flush_r    <= 1'b1;
                  redirect_r <= redirect_next_s;
                  miss_cnt_r <= sat_inc16(miss_cnt_r);
               end else begin
                  flush_r    <= 1'b0;
               end
            end
            FLUSH: begin
               state_r     <= DRAIN;
               drain_cnt_r <= 2'd0;
               flush_r     <= 1'b0;
            end
            DRAIN: begin
               flush_r <= 1'b0;
               if (drain_cnt_r == 2'(DRAIN_LEN - 1)) state_r <= RUN;
               else drain_cnt_r <= drain_cnt_r + 2'd1;
            end
            default: begin
               state_r <= RUN;
               flush_r <= 1'b0;
            end
         endcase
      end
   end

   // Resolved-branch count and sticky empty-resolve flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         br_cnt_r <= 16'd0;
         q_err_r  <= 1'b0;
      end else begin
         if (bus.mem_branch) br_cnt_r <= sat_inc16(br_cnt_r);
         if (empty_pop_s)    q_err_r  <= 1'b1;
      end
   end

   assign bus.predict     = predict_s;
   assign bus.flush       = flush_r;
   assign bus.redirect_pc = redirect_r;
   assign bus.q_full      = fifo_full_s;
   assign bus.br_count    = br_cnt_r;
   assign bus.miss_count  = miss_cnt_r;
   assign bus.q_err       = q_err_r;

endmodule

// File: tb/tb_branch_predictor_320.sv
// Self-checking bench for branch_predictor_320: directed vector table,
// a reset-during-recovery sequence, then randomized traffic against a
// behavioural model (counter array + SV queue + blocked-cycle countdown).
module tb_branch_predictor_320;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   branch_predictor_320_if bus();

   branch_predictor_320 #(.IDX_W(6), .QDEPTH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic drive(input logic idb, input logic stl, input logic [31:0] idpc,
                        input logic mb, input logic [31:0] mpc, input logic mt,
                        input logic [31:0] mtgt);
      bus.id_branch  = idb;
      bus.stall      = stl;
      bus.id_pc      = idpc;
      bus.mem_branch = mb;
      bus.mem_pc     = mpc;
      bus.mem_taken  = mt;
      bus.mem_target = mtgt;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        idb;
      logic [31:0] idpc;
      logic        mb;
      logic [31:0] mpc;
      logic        mt;
      logic [31:0] mtgt;
      logic        e_pred;
      logic        e_flush;
      logic [31:0] e_redir;
      logic        e_full;
      logic        e_qerr;
      logic [15:0] e_br;
      logic [15:0] e_miss;
   } vec_t;

   function automatic vec_t mk(input logic idb, input logic [31:0] idpc, input logic mb,
                               input logic [31:0] mpc, input logic mt, input logic [31:0] mtgt,
                               input logic ep, input logic ef, input logic [31:0] er,
                               input logic efu, input logic eq, input int ebr, input int emiss);
      vec_t v;
      v.idb = idb; v.idpc = idpc; v.mb = mb; v.mpc = mpc; v.mt = mt; v.mtgt = mtgt;
      v.e_pred = ep; v.e_flush = ef; v.e_redir = er; v.e_full = efu; v.e_qerr = eq;
      v.e_br = 16'(ebr); v.e_miss = 16'(emiss);
      return v;
   endfunction

   vec_t vecs[24];

   // ---------------- behavioural model ----------------
   typedef struct { int idx; bit pred; } ent_t;
   int          m_tbl[64];
   ent_t        m_q[$];
   int          m_block;
   bit          m_flush;
   logic [31:0] m_redir;
   int          m_br;
   int          m_miss;
   bit          m_qerr;

   function automatic int idx_of(input logic [31:0] pc);
      return int'((pc / 32'd4) % 32'd64);
   endfunction

   task automatic model_reset();
      foreach (m_tbl[i]) m_tbl[i] = 1;
      m_q.delete();
      m_block = 0; m_flush = 1'b0; m_redir = 32'd0;
      m_br = 0; m_miss = 0; m_qerr = 1'b0;
   endtask

   task automatic model_step(input logic idb, input logic stl, input logic [31:0] idpc,
                             input logic mb, input logic [31:0] mpc, input logic mt,
                             input logic [31:0] mtgt);
      bit running, pop, push, full, miss, p;
      ent_t e;
      running = (m_block == 0);
      pop     = mb && running;
      full    = (m_q.size() == 4);
      push    = idb && !stl && running && (!full || pop);
      miss    = 1'b0;
      if (m_block == 3) m_q.delete();
      if (pop) begin
         if (m_q.size() == 0) begin p = 1'b0; m_qerr = 1'b1; end
         else begin e = m_q.pop_front(); p = e.pred; end
         miss = (p != mt);
      end
      if (push) begin
         e.idx = idx_of(idpc);
         e.pred = (m_tbl[e.idx] >= 2);
         m_q.push_back(e);
      end
      if (mb) begin
         if (mt) m_tbl[idx_of(mpc)] = (m_tbl[idx_of(mpc)] == 3) ? 3 : m_tbl[idx_of(mpc)] + 1;
         else    m_tbl[idx_of(mpc)] = (m_tbl[idx_of(mpc)] == 0) ? 0 : m_tbl[idx_of(mpc)] - 1;
         m_br = (m_br == 65535) ? 65535 : m_br + 1;
      end
      m_flush = miss;
      if (miss) begin
         m_redir = mt ? mtgt : mpc + 32'd4;
         m_miss  = (m_miss == 65535) ? 65535 : m_miss + 1;
         m_block = 3;
      end else if (m_block > 0) begin
         m_block--;
      end
   endtask

   initial begin
      drive(1'b0, 1'b0, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_predict", 32'(bus.predict), 32'd0);
      check("rst_flush", 32'(bus.flush), 32'd0);
      check("rst_redirect", bus.redirect_pc, 32'd0);
      check("rst_q_full", 32'(bus.q_full), 32'd0);
      check("rst_q_err", 32'(bus.q_err), 32'd0);
      check("rst_br", 32'(bus.br_count), 32'd0);
      check("rst_miss", 32'(bus.miss_count), 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      //              idb  idpc   mb  mpc    mt  mtgt      pred flush redir   full qerr br miss
      vecs[0]  = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 0, 0);
      vecs[1]  = mk(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h80,   1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 0, 0);
      vecs[2]  = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1, 1'b1, 32'h80,  1'b0, 1'b0, 1, 1);
      vecs[3]  = mk(1'b1, 32'h40, 1'b1, 32'h100,1'b1, 32'h200,  1'b1, 1'b0, 32'h80,  1'b0, 1'b0, 1, 1);
      vecs[4]  = mk(1'b1, 32'h100,1'b1, 32'h40, 1'b1, 32'h80,   1'b1, 1'b0, 32'h80,  1'b0, 1'b0, 2, 1);
      vecs[5]  = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1, 1'b0, 32'h80,  1'b0, 1'b0, 3, 1);
      vecs[6]  = mk(1'b1, 32'h44, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 32'h80,  1'b0, 1'b0, 3, 1);
      vecs[7]  = mk(1'b1, 32'h48, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 32'h80,  1'b0, 1'b0, 3, 1);
      vecs[8]  = mk(1'b1, 32'h4C, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 32'h80,  1'b0, 1'b0, 3, 1);
      vecs[9]  = mk(1'b1, 32'h50, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b0, 32'h80,  1'b1, 1'b0, 3, 1);
      vecs[10] = mk(1'b1, 32'h54, 1'b1, 32'h40, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h80,  1'b1, 1'b0, 3, 1);
      vecs[11] = mk(1'b0, 32'h40, 1'b1, 32'h44, 1'b0, 32'h0,    1'b1, 1'b0, 32'h80,  1'b1, 1'b0, 4, 1);
      vecs[12] = mk(1'b0, 32'h48, 1'b1, 32'h48, 1'b0, 32'h0,    1'b0, 1'b0, 32'h80,  1'b0, 1'b0, 5, 1);
      vecs[13] = mk(1'b1, 32'h100,1'b1, 32'h4C, 1'b0, 32'h0,    1'b1, 1'b0, 32'h80,  1'b0, 1'b0, 6, 1);
      vecs[14] = mk(1'b0, 32'h54, 1'b1, 32'h54, 1'b0, 32'h0,    1'b0, 1'b0, 32'h80,  1'b0, 1'b0, 7, 1);
      vecs[15] = mk(1'b0, 32'h100,1'b1, 32'h100,1'b0, 32'h300,  1'b1, 1'b0, 32'h80,  1'b0, 1'b0, 8, 1);
      vecs[16] = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1, 1'b1, 32'h104, 1'b0, 1'b0, 9, 2);
      vecs[17] = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 9, 2);
      vecs[18] = mk(1'b1, 32'h40, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 9, 2);
      vecs[19] = mk(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h500,  1'b1, 1'b0, 32'h104, 1'b0, 1'b0, 9, 2);
      vecs[20] = mk(1'b0, 32'h14, 1'b0, 32'h0,  1'b0, 32'h0,    1'b0, 1'b1, 32'h500, 1'b0, 1'b1, 10, 3);
      vecs[21] = mk(1'b1, 32'h14, 1'b1, 32'h14, 1'b1, 32'h600,  1'b0, 1'b0, 32'h500, 1'b0, 1'b1, 10, 3);
      vecs[22] = mk(1'b1, 32'h14, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1, 1'b0, 32'h500, 1'b0, 1'b1, 11, 3);
      vecs[23] = mk(1'b0, 32'h14, 1'b0, 32'h0,  1'b0, 32'h0,    1'b1, 1'b0, 32'h500, 1'b0, 1'b1, 11, 3);

      for (int i = 0; i < 24; i++) begin
         drive(vecs[i].idb, 1'b0, vecs[i].idpc, vecs[i].mb, vecs[i].mpc, vecs[i].mt, vecs[i].mtgt);
         @(negedge clk);
         check($sformatf("v%0d_predict", i), 32'(bus.predict), 32'(vecs[i].e_pred));
         check($sformatf("v%0d_flush", i), 32'(bus.flush), 32'(vecs[i].e_flush));
         check($sformatf("v%0d_redirect", i), bus.redirect_pc, vecs[i].e_redir);
         check($sformatf("v%0d_q_full", i), 32'(bus.q_full), 32'(vecs[i].e_full));
         check($sformatf("v%0d_q_err", i), 32'(bus.q_err), 32'(vecs[i].e_qerr));
         check($sformatf("v%0d_br", i), 32'(bus.br_count), 32'(vecs[i].e_br));
         check($sformatf("v%0d_miss", i), 32'(bus.miss_count), 32'(vecs[i].e_miss));
         @(posedge clk); #1;
      end

      // Reset asserted while in FLUSH aborts recovery.
      drive(1'b0, 1'b0, 32'h14, 1'b1, 32'h200, 1'b1, 32'h40);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h14, 1'b0, 32'h0, 1'b0, 32'h0);
      check("seq_flush_set", 32'(bus.flush), 32'd1);
      check("seq_redirect", bus.redirect_pc, 32'h40);
      rst_n = 1'b0;
      #1;
      check("async_flush", 32'(bus.flush), 32'd0);
      check("async_redirect", bus.redirect_pc, 32'd0);
      check("async_q_err", 32'(bus.q_err), 32'd0);
      check("async_br", 32'(bus.br_count), 32'd0);
      check("async_miss", 32'(bus.miss_count), 32'd0);
      check("async_table", 32'(bus.predict), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_flush", 32'(bus.flush), 32'd0);
      drive(1'b0, 1'b0, 32'h14, 1'b1, 32'h0, 1'b0, 32'h0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 32'h14, 1'b0, 32'h0, 1'b0, 32'h0);
      check("post_rst_run_q_err", 32'(bus.q_err), 32'd1);
      check("post_rst_run_flush", 32'(bus.flush), 32'd0);
      check("post_rst_run_br", 32'(bus.br_count), 32'd1);

      // Randomized traffic against the model.
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      for (int c = 0; c < 800; c++) begin
         logic        idb, stl, mb, mt;
         logic [31:0] idpc, mpc, mtgt;
         idb  = ($urandom_range(0, 3) != 0);
         stl  = ($urandom_range(0, 4) == 0);
         mb   = ($urandom_range(0, 2) == 0);
         idpc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
         mpc  = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2);
         mtgt = $urandom;
         if (m_q.size() != 0 && $urandom_range(0, 3) != 0) mt = m_q[0].pred;
         else mt = 1'($urandom_range(0, 1));
         drive(idb, stl, idpc, mb, mpc, mt, mtgt);
         @(negedge clk);
         check("rnd_predict", 32'(bus.predict), 32'(m_tbl[idx_of(idpc)] >= 2));
         check("rnd_flush", 32'(bus.flush), 32'(m_flush));
         check("rnd_redirect", bus.redirect_pc, m_redir);
         check("rnd_q_full", 32'(bus.q_full), 32'(m_q.size() == 4));
         check("rnd_q_err", 32'(bus.q_err), 32'(m_qerr));
         check("rnd_br", 32'(bus.br_count), 32'(m_br));
         check("rnd_miss", 32'(bus.miss_count), 32'(m_miss));
         model_step(idb, stl, idpc, mb, mpc, mt, mtgt);
         @(posedge clk); #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
